// File: rtl/pixel_ctrl_pkg.sv
// Shared types and defaults for the pixel sensor sequencer.
// Used by pixel_sensor_ctrl and pixel_phase_timer.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  localparam int ERASE_CYCLES_DEF = 5;
  localparam int RAMP_STEPS_DEF   = 256;
  localparam int READ_CYCLES_DEF  = 4;
  localparam int EXP_W_DEF        = 8;
  localparam int CNT_W_DEF        = 10;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // True for every state that drives the pixel.
  function automatic logic is_busy(state_t s);
    return s != S_IDLE;
  endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// Phase counter: synchronous clear, terminal-count compare,
// last-cycle flag and parity of the upcoming count.
module pixel_phase_timer
  import pixel_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             last_o,
  output logic             odd_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart at zero on phase entry, else advance.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == tc_i);
  assign odd_o  = cnt_d[0];

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Pixel sensor frame sequencer: ERASE, EXPOSE, CONVERT, READ.
// Optional macro PIXEL_CTRL_CONTINUOUS_EN: chain frames while START held.
module pixel_sensor_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEF,
  parameter int RAMP_STEPS   = RAMP_STEPS_DEF,
  parameter int READ_CYCLES  = READ_CYCLES_DEF,
  parameter int EXP_W        = EXP_W_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [EXP_W-1:0] EXPOSE_LEN,
  output logic             ERASE,
  output logic             EXPOSE,
  output logic             VBN1,
  output logic             RAMP,
  output logic             READ,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       STATE
);

  localparam logic [CNT_W-1:0] TC_ERASE =
    CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_CONV =
    CNT_W'(2 * RAMP_STEPS - 1);
  localparam logic [CNT_W-1:0] TC_READ =
    CNT_W'(READ_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [EXP_W-1:0] len_q;
  logic [EXP_W-1:0] len_d;
  logic [CNT_W-1:0] tc;
  logic             last;
  logic             odd;
  logic             clr;
  logic             frame_end;

  logic erase_q, expose_q, vbn1_q, ramp_q;
  logic read_q, busy_q, done_q;

  // Next state, length latch and terminal count of the phase.
  // START is not taken in the DONE cycle, so a held START
  // still leaves one plain IDLE cycle between frames.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tc      = '0;
    case (state_q)
      S_IDLE: begin
        if (START && !done_q) begin
          state_d = S_ERASE;
          len_d   = EXPOSE_LEN;
        end
      end
      S_ERASE: begin
        tc = TC_ERASE;
        if (last) begin
          state_d = (len_q == '0) ? S_CONVERT : S_EXPOSE;
        end
      end
      S_EXPOSE: begin
        tc = CNT_W'(len_q) - CNT_W'(1);
        if (last) begin
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        tc = TC_CONV;
        if (last) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        tc = TC_READ;
        if (last) begin
`ifdef PIXEL_CTRL_CONTINUOUS_EN
          if (START) begin
            state_d = S_ERASE;
            len_d   = EXPOSE_LEN;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_end = (state_q == S_READ) && last;

  // Counter restarts on every phase change and idles at zero.
  assign clr = (state_d != state_q) || (state_q == S_IDLE);

  pixel_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (clr),
    .tc_i   (tc),
    .last_o (last),
    .odd_o  (odd)
  );

  // FSM and Moore output flops, decoded from the coming state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      erase_q  <= 1'b0;
      expose_q <= 1'b0;
      vbn1_q   <= 1'b0;
      ramp_q   <= 1'b0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      erase_q  <= (state_d == S_ERASE);
      expose_q <= (state_d == S_EXPOSE);
      vbn1_q   <= (state_d == S_EXPOSE) && odd;
      ramp_q   <= (state_d == S_CONVERT) && odd;
      read_q   <= (state_d == S_READ);
      busy_q   <= is_busy(state_d);
      done_q   <= frame_end;
    end
  end

  assign ERASE  = erase_q;
  assign EXPOSE = expose_q;
  assign VBN1   = vbn1_q;
  assign RAMP   = ramp_q;
  assign READ   = read_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign STATE  = state_q;

endmodule
